// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB from one-hot decoder
// class flags, with a memory-wait timeout, illegal-class trap and retired-instruction counter.
module multicycle_controller #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             r_type,
   input  logic             i_type,
   input  logic             store,
   input  logic             branch,
   input  logic             load,
   input  logic             jal,
   input  logic             jalr,
   input  logic             auipc,
   input  logic             lui,
   input  logic             branch_taken,
   input  logic             mem_ready,
   output logic             fetch_req,
   output logic             ir_write,
   output logic             mem_read,
   output logic             mem_write,
   output logic             reg_write,
   output logic             pc_write,
   output logic [1:0]       pc_sel,
   output logic [2:0]       imme_sel,
   output logic [1:0]       rd_sel,
   output logic [1:0]       rs1_sel,
   output logic             retire,
   output logic [CNT_W-1:0] retired,
   output logic             trap,
   output logic [1:0]       trap_cause
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
   } state_t;

   // Bit positions inside the latched class vector
   localparam int C_R     = 8;
   localparam int C_I     = 7;
   localparam int C_ST    = 6;
   localparam int C_BR    = 5;
   localparam int C_LD    = 4;
   localparam int C_JAL   = 3;
   localparam int C_JALR  = 2;
   localparam int C_AUIPC = 1;
   localparam int C_LUI   = 0;

   // The counter only needs to reach MEM_TIMEOUT-1; the trap fires on the next miss
   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   state_t            state, state_next;
   logic [8:0]        cls;
   logic [8:0]        class_flags;
   logic [WAIT_W-1:0] wait_cnt;
   logic [1:0]        cause_next;
   logic              timeout_hit;
   logic              in_wait_state;

   assign class_flags   = {r_type, i_type, store, branch, load, jal, jalr, auipc, lui};
   assign in_wait_state = (state == S_FETCH) || (state == S_MEM);
   assign timeout_hit   = (MEM_TIMEOUT != 0) && !mem_ready &&
                          (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Class latch, wait counter, trap cause and retired count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cls        <= '0;
         wait_cnt   <= '0;
         trap_cause <= 2'b00;
         retired    <= '0;
      end else begin
         if (state == S_DECODE) begin
            cls <= class_flags;
         end
         if ((state_next == S_FETCH || state_next == S_MEM) && state_next != state) begin
            wait_cnt <= '0;
         end else if (in_wait_state && !mem_ready) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
         end
         if (state_next == S_TRAP && state != S_TRAP) begin
            trap_cause <= cause_next;
         end
         if (retire) begin
            retired <= retired + CNT_W'(1);
         end
      end
   end

   // Next-state and output decode from state plus latched class
   always_comb begin
      state_next = state;
      cause_next = 2'b00;
      fetch_req  = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      pc_write   = 1'b0;
      pc_sel     = 2'b00;
      imme_sel   = 3'b000;
      rd_sel     = 2'b00;
      rs1_sel    = 2'b00;
      retire     = 1'b0;
      trap       = 1'b0;

      if (state == S_EXEC || state == S_MEM || state == S_WB) begin
         if (cls[C_I] || cls[C_LD] || cls[C_JALR]) begin
            imme_sel = 3'b001;
         end else if (cls[C_BR]) begin
            imme_sel = 3'b010;
         end else if (cls[C_ST]) begin
            imme_sel = 3'b011;
         end else if (cls[C_AUIPC] || cls[C_LUI]) begin
            imme_sel = 3'b100;
         end else if (cls[C_JAL]) begin
            imme_sel = 3'b101;
         end
         if (cls[C_BR] || cls[C_AUIPC]) begin
            rs1_sel = 2'b01;
         end else if (cls[C_JAL]) begin
            rs1_sel = 2'b10;
         end
      end

      case (state)
         S_IDLE: begin
            state_next = S_FETCH;
         end
         S_FETCH: begin
            fetch_req = 1'b1;
            if (mem_ready) begin
               ir_write   = 1'b1;
               state_next = S_DECODE;
            end else if (timeout_hit) begin
               state_next = S_TRAP;
               cause_next = 2'b10;
            end
         end
         S_DECODE: begin
            if ($onehot(class_flags)) begin
               state_next = S_EXEC;
            end else begin
               state_next = S_TRAP;
               cause_next = 2'b01;
            end
         end
         S_EXEC: begin
            if (cls[C_BR]) begin
               pc_write   = 1'b1;
               pc_sel     = branch_taken ? 2'b01 : 2'b00;
               retire     = 1'b1;
               state_next = S_FETCH;
            end else if (cls[C_LD] || cls[C_ST]) begin
               state_next = S_MEM;
            end else begin
               state_next = S_WB;
            end
         end
         S_MEM: begin
            mem_read  = cls[C_LD];
            mem_write = cls[C_ST];
            if (mem_ready) begin
               if (cls[C_ST]) begin
                  pc_write   = 1'b1;
                  retire     = 1'b1;
                  state_next = S_FETCH;
               end else begin
                  state_next = S_WB;
               end
            end else if (timeout_hit) begin
               state_next = S_TRAP;
               cause_next = 2'b10;
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            pc_write   = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
            if (cls[C_JAL]) begin
               pc_sel = 2'b01;
            end else if (cls[C_JALR]) begin
               pc_sel = 2'b10;
            end
            if (cls[C_JAL] || cls[C_JALR]) begin
               rd_sel = 2'b01;
            end else if (cls[C_LUI]) begin
               rd_sel = 2'b10;
            end else if (cls[C_LD]) begin
               rd_sel = 2'b11;
            end
         end
         S_TRAP: begin
            trap = 1'b1;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller built with MEM_TIMEOUT=4 and CNT_W=4 so the
// timeout and counter-wrap behaviour is reachable in a short run.
module tb_multicycle_controller;

   localparam logic [8:0] F_R     = 9'h100;
   localparam logic [8:0] F_I     = 9'h080;
   localparam logic [8:0] F_ST    = 9'h040;
   localparam logic [8:0] F_BR    = 9'h020;
   localparam logic [8:0] F_LD    = 9'h010;
   localparam logic [8:0] F_JAL   = 9'h008;
   localparam logic [8:0] F_JALR  = 9'h004;
   localparam logic [8:0] F_AUIPC = 9'h002;
   localparam logic [8:0] F_LUI   = 9'h001;

   logic       clk = 1'b0;
   logic       rst;
   logic       r_type, i_type, store, branch, load, jal, jalr, auipc, lui;
   logic       branch_taken, mem_ready;
   logic       fetch_req, ir_write, mem_read, mem_write, reg_write, pc_write;
   logic [1:0] pc_sel, rd_sel, rs1_sel, trap_cause;
   logic [2:0] imme_sel;
   logic       retire, trap;
   logic [3:0] retired;
   logic [7:0] strobes;
   logic [8:0] sels;

   int total = 0;
   int bad   = 0;

   // Strobe bits: fetch_req ir_write mem_read mem_write reg_write pc_write retire trap
   assign strobes = {fetch_req, ir_write, mem_read, mem_write, reg_write, pc_write, retire, trap};
   assign sels    = {pc_sel, imme_sel, rd_sel, rs1_sel};

   always #5 clk = ~clk;

   multicycle_controller #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .r_type(r_type), .i_type(i_type), .store(store), .branch(branch), .load(load),
      .jal(jal), .jalr(jalr), .auipc(auipc), .lui(lui),
      .branch_taken(branch_taken), .mem_ready(mem_ready),
      .fetch_req(fetch_req), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
      .reg_write(reg_write), .pc_write(pc_write), .pc_sel(pc_sel), .imme_sel(imme_sel),
      .rd_sel(rd_sel), .rs1_sel(rs1_sel), .retire(retire), .retired(retired),
      .trap(trap), .trap_cause(trap_cause)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [8:0] f, input logic rdy, input logic taken);
      {r_type, i_type, store, branch, load, jal, jalr, auipc, lui} = f;
      mem_ready    = rdy;
      branch_taken = taken;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [8:0] cls_tab [4];
   logic [8:0] sel_tab [4];

   initial begin
      cls_tab = '{F_I, F_JALR, F_AUIPC, F_LUI};
      sel_tab = '{9'b00_001_00_00, 9'b10_001_01_00, 9'b00_100_00_01, 9'b00_100_10_00};

      rst = 1'b1;
      applyStimulus(9'h000, 1'b0, 1'b0);
      checkOutput("reset strobes", strobes, 8'h00);
      checkOutput("reset sels", sels, 9'h000);
      checkOutput("reset retired", retired, 4'd0);
      checkOutput("reset cause", trap_cause, 2'b00);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      #1 checkOutput("idle strobes", strobes, 8'h00);

      // R-type with memory always ready: 4 cycles
      tick();
      applyStimulus(F_R, 1'b1, 1'b0);
      checkOutput("t1 fetch", strobes, 8'hC0);
      tick();
      checkOutput("t1 decode", strobes, 8'h00);
      tick();
      checkOutput("t1 exec", strobes, 8'h00);
      tick();
      checkOutput("t1 wb strobes", strobes, 8'h0E);
      checkOutput("t1 wb sels", sels, 9'b00_000_00_00);
      checkOutput("t1 retired pre", retired, 4'd0);
      tick();
      checkOutput("t1 retired", retired, 4'd1);

      // Load with three not-ready MEM cycles
      applyStimulus(F_LD, 1'b1, 1'b0);
      checkOutput("t2 fetch", strobes, 8'hC0);
      tick();
      tick();
      checkOutput("t2 exec imm", imme_sel, 3'b001);
      applyStimulus(F_LD, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("t2 mem wait", strobes, 8'h20);
      end
      tick();
      applyStimulus(F_LD, 1'b1, 1'b0);
      checkOutput("t2 mem ready", strobes, 8'h20);
      tick();
      checkOutput("t2 wb strobes", strobes, 8'h0E);
      checkOutput("t2 wb sels", sels, 9'b00_001_11_00);
      tick();
      checkOutput("t2 retired", retired, 4'd2);

      // Branch taken then not taken
      applyStimulus(F_BR, 1'b1, 1'b1);
      tick();
      tick();
      checkOutput("t3 taken strobes", strobes, 8'h06);
      checkOutput("t3 taken sels", sels, 9'b01_010_00_01);
      tick();
      checkOutput("t3 retired a", retired, 4'd3);
      checkOutput("t3 back to fetch", strobes, 8'hC0);
      applyStimulus(F_BR, 1'b1, 1'b0);
      tick();
      tick();
      checkOutput("t3 not taken strobes", strobes, 8'h06);
      checkOutput("t3 not taken sels", sels, 9'b00_010_00_01);
      tick();
      checkOutput("t3 retired b", retired, 4'd4);

      // Store completing immediately: 4 cycles
      applyStimulus(F_ST, 1'b1, 1'b0);
      tick();
      tick();
      checkOutput("st exec strobes", strobes, 8'h00);
      checkOutput("st exec imm", imme_sel, 3'b011);
      tick();
      checkOutput("st mem strobes", strobes, 8'h16);
      checkOutput("st mem sels", sels, 9'b00_011_00_00);
      tick();
      checkOutput("st retired", retired, 4'd5);

      // Reset while a store is waiting in MEM
      applyStimulus(F_ST, 1'b1, 1'b0);
      tick();
      tick();
      applyStimulus(F_ST, 1'b0, 1'b0);
      tick();
      checkOutput("t6 mem pending", strobes, 8'h10);
      rst = 1'b1;
      #1;
      checkOutput("t6 reset strobes", strobes, 8'h00);
      checkOutput("t6 reset retired", retired, 4'd0);
      tick();
      rst = 1'b0;
      applyStimulus(9'h000, 1'b1, 1'b0);
      checkOutput("t6 idle", strobes, 8'h00);
      tick();
      checkOutput("t6 fetch", strobes, 8'hC0);

      // Sixteen jal instructions wrap the 4-bit counter
      applyStimulus(F_JAL, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) begin
         logic [3:0] exp_ret;
         exp_ret = 4'(i + 1);
         tick();
         tick();
         checkOutput("t7 exec sels", {imme_sel, rs1_sel}, 5'b101_10);
         tick();
         checkOutput("t7 wb strobes", strobes, 8'h0E);
         checkOutput("t7 wb sels", sels, 9'b01_101_01_10);
         tick();
         checkOutput("t7 retired", retired, exp_ret);
      end
      checkOutput("t7 wrap", retired, 4'd0);

      // Remaining write-back classes
      for (int k = 0; k < 4; k++) begin
         applyStimulus(cls_tab[k], 1'b1, 1'b0);
         tick();
         tick();
         tick();
         checkOutput("wb class strobes", strobes, 8'h0E);
         checkOutput("wb class sels", sels, sel_tab[k]);
         tick();
         checkOutput("wb class retired", retired, 4'(k + 1));
      end

      // Fetch timeout after four not-ready cycles
      applyStimulus(9'h000, 1'b0, 1'b0);
      checkOutput("t5 fetch 1", strobes, 8'h80);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("t5 fetch wait", strobes, 8'h80);
      end
      tick();
      checkOutput("t5 trap strobes", strobes, 8'h01);
      checkOutput("t5 trap cause", trap_cause, 2'b10);
      tick();
      checkOutput("t5 trap held", strobes, 8'h01);

      // Two class flags at once is illegal
      rst = 1'b1;
      #1;
      checkOutput("t4 reset trap", strobes, 8'h00);
      checkOutput("t4 reset cause", trap_cause, 2'b00);
      tick();
      rst = 1'b0;
      tick();
      applyStimulus(F_LD | F_ST, 1'b1, 1'b0);
      tick();
      checkOutput("t4 decode", strobes, 8'h00);
      tick();
      checkOutput("t4 trap strobes", strobes, 8'h01);
      checkOutput("t4 trap cause", trap_cause, 2'b01);
      repeat (3) tick();
      checkOutput("t4 trap stays", strobes, 8'h01);
      checkOutput("t4 cause stays", trap_cause, 2'b01);
      checkOutput("t4 retired", retired, 4'd0);

      // No class flag at all is illegal too
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      applyStimulus(9'h000, 1'b1, 1'b0);
      tick();
      tick();
      checkOutput("zero flags trap", strobes, 8'h01);
      checkOutput("zero flags cause", trap_cause, 2'b01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
